fwd_hazard_ctrl: RTL and testbench
==================================

// Module: fwd_hazard_ctrl
// PURPOSE
// - Forwarding/hazard controller for the 5-stage RISC-V core.
// - Tracks rd/write/load status of the instructions in EX, MEM and WB in its own shadow pipeline registers.
// - Drives the 2-bit selectors of the two EX-stage operand 3:1 muxes.
// - Raises a one-cycle load-use stall and keeps a saturating stall counter.
// PARAMETERS
// - RA_W   5   register address width
// - CNT_W  16  width of stall_count
// PORTS
// - clk           in   1      core clock, rising edge
// - reset         in   1      asynchronous, active-high
// - id_valid      in   1      instruction present in ID
// - id_rs1        in   RA_W   ID source reg 1
// - id_rs2        in   RA_W   ID source reg 2
// - id_use_rs1    in   1      ID instr reads rs1
// - id_use_rs2    in   1      ID instr reads rs2
// - id_rd         in   RA_W   ID destination reg
// - id_reg_write  in   1      ID instr writes rd
// - id_mem_read   in   1      ID instr is a load
// - flush         in   1      taken branch: squash ID instr entering EX
// - fwd_a_sel     out  2      operand A mux select: 0=regfile, 1=EX/MEM result, 2=MEM/WB result
// - fwd_b_sel     out  2      operand B mux select, same encoding
// - stall         out  1      hold PC and IF/ID; insert bubble into EX
// - stall_count   out  CNT_W  saturating count of stall cycles
// BEHAVIOUR
// - Shadow stages (each entry: valid, rd, rw; EX also holds rs1/rs2/use bits and mr):
//   ID -> EX -> MEM -> WB, advancing every clk.
// - Reset (async): all stage valids = 0; stall_count = 0.
//   Outputs then read fwd_a_sel = fwd_b_sel = 0, stall = 0.
// - Per-clk advance:
//   - MEM -> WB and EX -> MEM always.
//   - ID -> EX loads a bubble (valid = 0) when stall | flush | !id_valid.
//   - Otherwise ID -> EX loads the ID fields.
// - Hazard qualification: a stage counts only if valid & rw & (rd != 0). x0 is never forwarded or stalled on.
// - fwd_a_sel (combinational from EX entry):
//   - 1 if EX.use_rs1 & qualified MEM.rd == EX.rs1
//   - else 2 if EX.use_rs1 & qualified WB.rd == EX.rs1
//   - else 0
//   - MEM has priority over WB. fwd_b_sel: same rule with rs2.
// - Encoding 3 is never driven. If the EX entry is invalid, both sels = 0.
// - stall (combinational) = id_valid & EX qualified & EX.mr & ((id_use_rs1 & id_rs1 == EX.rd) | (id_use_rs2 & id_rs2 == EX.rd)).
// - Load-use cost: exactly 1 stall cycle.
//   - The next cycle the load is in MEM, so stall deasserts.
//   - The dependent instr later forwards from WB (sel 2).
// - flush & stall in the same cycle: bubble inserted; stall still asserted for that cycle and counted.
// - stall_count: +1 on each clk with stall = 1; holds at 2^CNT_W-1 (no wrap).
// - Reset mid-operation: all in-flight entries discarded immediately. No forwarding is asserted until new instrs reach MEM/WB.
// - Latency: sels valid in the same cycle the consumer is in EX. stall is valid in the same cycle the consumer is in ID.
// TESTING
// - Reset asserted mid-stream with all stages valid -> same cycle: sels = 0, stall = 0, stall_count = 0.
// - add x5 then add x6,x5,x1 back-to-back:
//   - 2nd instr in EX -> fwd_a_sel = 1, fwd_b_sel = 0, stall = 0.
// - lw x7 then add x8,x1,x7:
//   - stall = 1 for exactly 1 cycle; then fwd_b_sel = 2; stall_count = 1.
// - Writes to x3 in both MEM and WB; EX reads x3 on rs1 and rs2 -> fwd_a_sel = fwd_b_sel = 1 (MEM priority).
// - lw x0 then add x9,x0,x0 -> no stall, sels = 0.
// - Flush with lw x7 in ID -> next add x8,x7 sees no stall.
// - stall_count at max with a further stall -> stays 0xFFFF.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl
//   Forwarding and load-use hazard controller for the 5-stage RISC-V core.
//   It keeps its own shadow copy of the EX, MEM and WB pipeline registers
//   (valid, destination register, write enable, plus source/load info for EX).
//   From these it computes the EX-stage operand mux selects and the load-use
//   stall. It also keeps a saturating count of stall cycles.
//
// Ports
//   clk            core clock, rising edge
//   reset          asynchronous, active-high; discards all in-flight entries
//   id_valid       an instruction is present in ID
//   id_rs1/id_rs2  ID source registers
//   id_use_rs1/2   ID instruction actually reads rs1/rs2
//   id_rd          ID destination register
//   id_reg_write   ID instruction writes rd
//   id_mem_read    ID instruction is a load
//   flush          taken branch: the ID instruction must not enter EX
//   fwd_a_sel      operand A select: 0=regfile, 1=EX/MEM result, 2=MEM/WB result
//   fwd_b_sel      operand B select, same encoding
//   stall          hold PC and IF/ID, insert a bubble into EX
//   stall_count    saturating number of stall cycles since reset
module fwd_hazard_ctrl #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  // EX shadow entry
  logic            ex_valid;
  logic [RA_W-1:0] ex_rs1;
  logic [RA_W-1:0] ex_rs2;
  logic            ex_use_rs1;
  logic            ex_use_rs2;
  logic [RA_W-1:0] ex_rd;
  logic            ex_rw;
  logic            ex_mr;

  // MEM and WB shadow entries only need to describe what they will write
  logic            mem_valid;
  logic [RA_W-1:0] mem_rd;
  logic            mem_rw;
  logic            wb_valid;
  logic [RA_W-1:0] wb_rd;
  logic            wb_rw;

  // A stage is a forwarding/stall source only if it really writes a
  // register other than x0.
  logic ex_qual;
  logic mem_qual;
  logic wb_qual;

  assign ex_qual  = ex_valid  & ex_rw  & (ex_rd  != '0);
  assign mem_qual = mem_valid & mem_rw & (mem_rd != '0);
  assign wb_qual  = wb_valid  & wb_rw  & (wb_rd  != '0);

  // Operand selects: MEM is checked first because it holds the younger
  // producer, so its value supersedes anything sitting in WB.
  always_comb begin
    fwd_a_sel = 2'd0;
    fwd_b_sel = 2'd0;
    if (ex_valid) begin
      if (ex_use_rs1 && mem_qual && (mem_rd == ex_rs1)) begin
        fwd_a_sel = 2'd1;
      end else if (ex_use_rs1 && wb_qual && (wb_rd == ex_rs1)) begin
        fwd_a_sel = 2'd2;
      end
      if (ex_use_rs2 && mem_qual && (mem_rd == ex_rs2)) begin
        fwd_b_sel = 2'd1;
      end else if (ex_use_rs2 && wb_qual && (wb_rd == ex_rs2)) begin
        fwd_b_sel = 2'd2;
      end
    end
  end

  // A load in EX cannot forward to the instruction behind it in time, so the
  // consumer waits one cycle in ID; by then the load is in MEM and the
  // consumer later picks the data up from WB.
  assign stall = id_valid & ex_qual & ex_mr &
                 ((id_use_rs1 & (id_rs1 == ex_rd)) |
                  (id_use_rs2 & (id_rs2 == ex_rd)));

  // Shadow pipeline advance and stall counter. A stall or flush injects a
  // bubble into EX; the stall cycle is still counted even when a flush
  // coincides with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_use_rs1  <= 1'b0;
      ex_use_rs2  <= 1'b0;
      ex_rd       <= '0;
      ex_rw       <= 1'b0;
      ex_mr       <= 1'b0;
      mem_valid   <= 1'b0;
      mem_rd      <= '0;
      mem_rw      <= 1'b0;
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_rw       <= 1'b0;
      stall_count <= '0;
    end else begin
      wb_valid  <= mem_valid;
      wb_rd     <= mem_rd;
      wb_rw     <= mem_rw;
      mem_valid <= ex_valid;
      mem_rd    <= ex_rd;
      mem_rw    <= ex_rw;
      if (stall || flush || !id_valid) begin
        ex_valid   <= 1'b0;
        ex_rs1     <= '0;
        ex_rs2     <= '0;
        ex_use_rs1 <= 1'b0;
        ex_use_rs2 <= 1'b0;
        ex_rd      <= '0;
        ex_rw      <= 1'b0;
        ex_mr      <= 1'b0;
      end else begin
        ex_valid   <= 1'b1;
        ex_rs1     <= id_rs1;
        ex_rs2     <= id_rs2;
        ex_use_rs1 <= id_use_rs1;
        ex_use_rs2 <= id_use_rs2;
        ex_rd      <= id_rd;
        ex_rw      <= id_reg_write;
        ex_mr      <= id_mem_read;
      end
      if (stall && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl
//   Drives the forwarding/hazard controller with directed scenarios and a
//   randomized instruction stream. The reference model remembers the last
//   three instructions that entered EX (oldest first) and derives the
//   expected selects, stall and stall count from the forwarding rules.
//   A second, narrow-counter instance exercises counter saturation.
module tb_fwd_hazard_ctrl;

  typedef struct packed {
    logic       v;
    logic       rw;
    logic       mr;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } instr_t;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  id_rd;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        flush;
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic        stall;
  logic [15:0] stall_count;

  // narrow-counter instance
  logic        s_id_valid;
  logic [4:0]  s_id_rs1;
  logic        s_id_use_rs1;
  logic [4:0]  s_id_rd;
  logic        s_id_reg_write;
  logic        s_id_mem_read;
  logic [1:0]  s_fwd_a_sel;
  logic [1:0]  s_fwd_b_sel;
  logic        s_stall;
  logic [3:0]  s_stall_count;

  int checks = 0;
  int errors = 0;

  // model state: hist[0]=WB, hist[1]=MEM, hist[2]=EX
  instr_t      hist[$];
  int unsigned model_cnt;

  fwd_hazard_ctrl #(.RA_W(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall), .stall_count(stall_count)
  );

  fwd_hazard_ctrl #(.RA_W(5), .CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .id_valid(s_id_valid), .id_rs1(s_id_rs1), .id_rs2(5'd0),
    .id_use_rs1(s_id_use_rs1), .id_use_rs2(1'b0), .id_rd(s_id_rd),
    .id_reg_write(s_id_reg_write), .id_mem_read(s_id_mem_read), .flush(1'b0),
    .fwd_a_sel(s_fwd_a_sel), .fwd_b_sel(s_fwd_b_sel), .stall(s_stall), .stall_count(s_stall_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic qualifies(input instr_t i);
    return i.v && i.rw && (i.rd != 5'd0);
  endfunction

  // Youngest writer of rs wins; 1 = MEM, 2 = WB.
  function automatic logic [1:0] model_sel(input logic [4:0] rs, input logic use_rs);
    if (!hist[2].v || !use_rs) return 2'd0;
    if (qualifies(hist[1]) && hist[1].rd == rs) return 2'd1;
    if (qualifies(hist[0]) && hist[0].rd == rs) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic model_stall();
    instr_t ex;
    ex = hist[2];
    if (!id_valid || !qualifies(ex) || !ex.mr) return 1'b0;
    return (id_use_rs1 && id_rs1 == ex.rd) || (id_use_rs2 && id_rs2 == ex.rd);
  endfunction

  task automatic model_reset();
    instr_t b;
    b = '0;
    hist.delete();
    for (int i = 0; i < 3; i++) hist.push_back(b);
    model_cnt = 0;
  endtask

  // One clock edge; the model consumes the same ID inputs the DUT sees.
  task automatic advance();
    logic   st;
    instr_t n;
    st = model_stall();
    @(posedge clk);
    if (st && model_cnt < 65535) model_cnt++;
    n = '0;
    if (!(st || flush || !id_valid)) begin
      n.v = 1'b1; n.rw = id_reg_write; n.mr = id_mem_read;
      n.u1 = id_use_rs1; n.u2 = id_use_rs2;
      n.rd = id_rd; n.rs1 = id_rs1; n.rs2 = id_rs2;
    end
    hist.push_back(n);
    void'(hist.pop_front());
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic fl);
    id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr; flush = fl;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    advance();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    @(negedge clk);
    checks++; if (fwd_a_sel !== 2'd0) begin errors++; $display("[TB] FAIL reset_sel_a: got %0d expected 0", fwd_a_sel); end
    checks++; if (fwd_b_sel !== 2'd0) begin errors++; $display("[TB] FAIL reset_sel_b: got %0d expected 0", fwd_b_sel); end
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %0b expected 0", stall); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", stall_count); end
    reset = 1'b0;
    model_reset();
    advance();
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);   // add x5,x1,x2
    advance();
    set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);   // add x6,x5,x1
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL b2b_stall_id: got %0b expected 0", stall); end
    advance();
    idle();
    @(negedge clk);
    checks++; if (fwd_a_sel !== 2'd1) begin errors++; $display("[TB] FAIL b2b_sel_a: got %0d expected 1", fwd_a_sel); end
    checks++; if (fwd_b_sel !== 2'd0) begin errors++; $display("[TB] FAIL b2b_sel_b: got %0d expected 0", fwd_b_sel); end
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL b2b_stall: got %0b expected 0", stall); end
    advance();
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);   // lw x7,0(x1)
    advance();
    set_id(1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);   // add x8,x1,x7
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL lu_stall_first: got %0b expected 1", stall); end
    advance();
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL lu_stall_second: got %0b expected 0", stall); end
    checks++; if (fwd_b_sel !== 2'd0) begin errors++; $display("[TB] FAIL lu_bubble_sel_b: got %0d expected 0", fwd_b_sel); end
    advance();
    idle();
    @(negedge clk);
    checks++; if (fwd_b_sel !== 2'd2) begin errors++; $display("[TB] FAIL lu_sel_b: got %0d expected 2", fwd_b_sel); end
    checks++; if (fwd_a_sel !== 2'd0) begin errors++; $display("[TB] FAIL lu_sel_a: got %0d expected 0", fwd_a_sel); end
    checks++; if (stall_count !== 16'd1) begin errors++; $display("[TB] FAIL lu_count: got %0d expected 1", stall_count); end
    advance();
  endtask

  task automatic test_mem_priority();
    do_reset();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);   // add x3,x1,x2
    advance();
    set_id(1'b1, 5'd2, 1'b1, 5'd1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);   // add x3,x2,x1
    advance();
    set_id(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);  // add x10,x3,x3
    advance();
    idle();
    @(negedge clk);
    checks++; if (fwd_a_sel !== 2'd1) begin errors++; $display("[TB] FAIL prio_sel_a: got %0d expected 1", fwd_a_sel); end
    checks++; if (fwd_b_sel !== 2'd1) begin errors++; $display("[TB] FAIL prio_sel_b: got %0d expected 1", fwd_b_sel); end
    advance();
  endtask

  task automatic test_x0();
    do_reset();
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);   // lw x0,0(x1)
    advance();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);   // add x9,x0,x0
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL x0_stall: got %0b expected 0", stall); end
    advance();
    idle();
    @(negedge clk);
    checks++; if (fwd_a_sel !== 2'd0) begin errors++; $display("[TB] FAIL x0_sel_a: got %0d expected 0", fwd_a_sel); end
    checks++; if (fwd_b_sel !== 2'd0) begin errors++; $display("[TB] FAIL x0_sel_b: got %0d expected 0", fwd_b_sel); end
    advance();
  endtask

  task automatic test_flush();
    do_reset();
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1);   // lw x7, flushed
    advance();
    set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);   // add x8,x7,x0
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL flush_stall: got %0b expected 0", stall); end
    advance();
    idle();
    @(negedge clk);
    checks++; if (fwd_a_sel !== 2'd0) begin errors++; $display("[TB] FAIL flush_sel_a: got %0d expected 0", fwd_a_sel); end
    advance();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);   // lw x5
    advance();
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);   // add x8,x5 (stalls once)
    advance();
    advance();
    set_id(1'b1, 5'd8, 1'b1, 5'd5, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);   // add x9,x8,x5
    advance();
    set_id(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);  // add x10,x9
    advance();
    set_id(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0); // add x11,x10
    @(negedge clk);
    checks++; if (fwd_a_sel !== 2'd1) begin errors++; $display("[TB] FAIL mid_pre_sel_a: got %0d expected 1", fwd_a_sel); end
    checks++; if (stall_count !== 16'd1) begin errors++; $display("[TB] FAIL mid_pre_count: got %0d expected 1", stall_count); end
    reset = 1'b1;
    #1;
    checks++; if (fwd_a_sel !== 2'd0) begin errors++; $display("[TB] FAIL mid_sel_a: got %0d expected 0", fwd_a_sel); end
    checks++; if (fwd_b_sel !== 2'd0) begin errors++; $display("[TB] FAIL mid_sel_b: got %0d expected 0", fwd_b_sel); end
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL mid_stall: got %0b expected 0", stall); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("[TB] FAIL mid_count: got %0d expected 0", stall_count); end
    do_reset();
    set_id(1'b1, 5'd10, 1'b1, 5'd9, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0); // reads old producers
    advance();
    idle();
    @(negedge clk);
    checks++; if (fwd_a_sel !== 2'd0) begin errors++; $display("[TB] FAIL mid_after_sel_a: got %0d expected 0", fwd_a_sel); end
    checks++; if (fwd_b_sel !== 2'd0) begin errors++; $display("[TB] FAIL mid_after_sel_b: got %0d expected 0", fwd_b_sel); end
    advance();
  endtask

  task automatic test_random();
    logic [1:0] ea;
    logic [1:0] eb;
    logic       es;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 1'($urandom),
             5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
      @(negedge clk);
      ea = model_sel(hist[2].rs1, hist[2].u1);
      eb = model_sel(hist[2].rs2, hist[2].u2);
      es = model_stall();
      checks++; if (fwd_a_sel !== ea) begin errors++; $display("[TB] FAIL rand_sel_a cycle %0d: got %0d expected %0d", c, fwd_a_sel, ea); end
      checks++; if (fwd_b_sel !== eb) begin errors++; $display("[TB] FAIL rand_sel_b cycle %0d: got %0d expected %0d", c, fwd_b_sel, eb); end
      checks++; if (stall !== es) begin errors++; $display("[TB] FAIL rand_stall cycle %0d: got %0b expected %0b", c, stall, es); end
      checks++; if (stall_count !== 16'(model_cnt)) begin errors++; $display("[TB] FAIL rand_count cycle %0d: got %0d expected %0d", c, stall_count, model_cnt); end
      advance();
    end
    idle();
  endtask

  task automatic test_saturation();
    int exp_cnt;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      s_id_valid = 1'b1; s_id_rs1 = 5'd1; s_id_use_rs1 = 1'b1;
      s_id_rd = 5'd7; s_id_reg_write = 1'b1; s_id_mem_read = 1'b1;       // lw x7
      advance();
      s_id_rs1 = 5'd7; s_id_rd = 5'd8; s_id_mem_read = 1'b0;              // add x8,x7
      @(negedge clk);
      exp_cnt = (i < 15) ? i : 15;
      checks++; if (s_stall !== 1'b1) begin errors++; $display("[TB] FAIL sat_stall pair %0d: got %0b expected 1", i, s_stall); end
      checks++; if (s_stall_count !== 4'(exp_cnt)) begin errors++; $display("[TB] FAIL sat_count pair %0d: got %0d expected %0d", i, s_stall_count, exp_cnt); end
      advance();
    end
    s_id_valid = 1'b0;
    @(negedge clk);
    checks++; if (s_stall_count !== 4'd15) begin errors++; $display("[TB] FAIL sat_final: got %0d expected 15", s_stall_count); end
    advance();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    s_id_valid = 1'b0; s_id_rs1 = 5'd0; s_id_use_rs1 = 1'b0;
    s_id_rd = 5'd0; s_id_reg_write = 1'b0; s_id_mem_read = 1'b0;
    model_reset();
    test_reset();
    test_back_to_back();
    test_load_use();
    test_mem_priority();
    test_x0();
    test_flush();
    test_reset_midstream();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
